// File: rtl/ddr_read_arbiter_pkg.sv
// Shared DDR types and arbiter configuration for the read-port arbiter.
// Also carries the round-robin wrap helper used when advancing the pointer.
package ddr_read_arbiter_pkg;

    typedef logic [31:0] ddr_address_t;
    typedef logic [63:0] ddr_data_t;

    localparam int unsigned NumDdrRequesters     = 4;
    localparam int unsigned DdrReadTimeoutCycles = 1024;

    typedef logic [$clog2(NumDdrRequesters)-1:0] requester_id_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA
    } arb_state_e;

    // Index of the client after 'id', wrapping back to 0 past the last client.
    function automatic int unsigned wrap_next(input int unsigned id, input int unsigned n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/ddr_read_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping around; any_valid reports whether a grant exists at all.
module ddr_read_arbiter_rr_picker #(
    parameter int unsigned NumRequesters = 4,
    localparam int unsigned IdW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1
) (
    input  logic [NumRequesters-1:0] req,
    input  logic [IdW-1:0]           ptr,
    output logic [IdW-1:0]           grant,
    output logic                     any_valid
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NumRequesters; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NumRequesters) begin
                idx = idx - NumRequesters;
            end
            if (!any_valid && req[IdW'(idx)]) begin
                any_valid = 1'b1;
                grant     = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/ddr_read_arbiter.sv
// Shares the single DDR read port among several streaming clients, one read
// in flight at a time, granted round-robin with a per-read timeout.
module ddr_read_arbiter
    import ddr_read_arbiter_pkg::*;
#(
    parameter int unsigned NumRequesters = NumDdrRequesters,
    parameter int unsigned TimeoutCycles = DdrReadTimeoutCycles
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumRequesters-1:0]          req_valid_i,
    input  ddr_address_t [NumRequesters-1:0]  req_address_i,
    output logic [NumRequesters-1:0]          req_ready_o,
    output logic [NumRequesters-1:0]          rsp_valid_o,
    output ddr_data_t                         rsp_data_o,
    output logic                              rsp_error_o,
    output ddr_address_t                      ddr_address_o,
    output logic                              ddr_r_en_o,
    input  ddr_data_t                         ddr_r_data_i,
    input  logic                              ddr_r_valid_i,
    input  logic                              ddr_waitrequest_n_i,
    output logic                              busy_o,
    output logic                              timeout_sticky_o
);

    localparam int unsigned IdW  = $clog2(NumRequesters);
    localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;

    typedef logic [IdW-1:0]  id_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t CntLast = CntW'(TimeoutCycles - 1);
    localparam logic [NumRequesters-1:0] OneHotBase = NumRequesters'(1);

    arb_state_e state_q, state_d;

    id_t          rr_ptr_q;
    id_t          grant_q;
    ddr_address_t addr_q;
    cnt_t         cnt_q;

    logic [NumRequesters-1:0] rsp_valid_q;
    logic                     rsp_error_q;
    ddr_data_t                rsp_data_q;
    logic                     sticky_q;

    id_t  pick_id;
    logic pick_any;

    logic accept;
    logic launch;
    logic rsp_ok;
    logic rsp_timeout;
    logic wait_tick;

    ddr_read_arbiter_rr_picker #(
        .NumRequesters(NumRequesters)
    ) u_picker (
        .req      (req_valid_i),
        .ptr      (rr_ptr_q),
        .grant    (pick_id),
        .any_valid(pick_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The ready pulse is combinational so a request is accepted in the very
    // cycle the arbiter is idle, including the cycle a response is visible.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        launch        = 1'b0;
        rsp_ok        = 1'b0;
        rsp_timeout   = 1'b0;
        wait_tick     = 1'b0;
        req_ready_o   = '0;
        ddr_r_en_o    = 1'b0;
        ddr_address_o = '0;
        busy_o        = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (pick_any && rst_ni) begin
                    accept      = 1'b1;
                    req_ready_o = OneHotBase << pick_id;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                ddr_r_en_o    = 1'b1;
                ddr_address_o = addr_q;
                if (ddr_waitrequest_n_i) begin
                    launch  = 1'b1;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (ddr_r_valid_i && ddr_waitrequest_n_i) begin
                    rsp_ok  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CntLast) begin
                    rsp_timeout = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q <= '0;
            addr_q  <= '0;
        end else if (accept) begin
            grant_q <= pick_id;
            addr_q  <= req_address_i[pick_id];
        end
    end

    // Saturating wait counter; restarted whenever a read leaves ISSUE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (launch) begin
            cnt_q <= '0;
        end else if (wait_tick && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Response pulse lasts one cycle; data holds until the next completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
            sticky_q    <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= '0;
            rsp_error_q <= 1'b0;
            if (rsp_ok) begin
                rsp_valid_q <= OneHotBase << grant_q;
                rsp_data_q  <= ddr_r_data_i;
                rr_ptr_q    <= id_t'(wrap_next(32'(grant_q), NumRequesters));
            end else if (rsp_timeout) begin
                rsp_valid_q <= OneHotBase << grant_q;
                rsp_error_q <= 1'b1;
                rsp_data_q  <= '0;
                sticky_q    <= 1'b1;
                rr_ptr_q    <= id_t'(wrap_next(32'(grant_q), NumRequesters));
            end
        end
    end

    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_error_o      = rsp_error_q;
    assign rsp_data_o       = rsp_data_q;
    assign timeout_sticky_o = sticky_q;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Randomised scoreboard bench for ddr_read_arbiter: a transaction-level model
// predicts grants and responses, a monitor compares every response pulse.
module tb_ddr_read_arbiter;
    import ddr_read_arbiter_pkg::*;

    localparam int NumReq  = 4;
    localparam int Timeout = 8;

    logic                        clk_i = 1'b0;
    logic                        rst_ni = 1'b0;
    logic [NumReq-1:0]           req_valid_i;
    ddr_address_t [NumReq-1:0]   req_address_i;
    logic [NumReq-1:0]           req_ready_o;
    logic [NumReq-1:0]           rsp_valid_o;
    ddr_data_t                   rsp_data_o;
    logic                        rsp_error_o;
    ddr_address_t                ddr_address_o;
    logic                        ddr_r_en_o;
    ddr_data_t                   ddr_r_data_i;
    logic                        ddr_r_valid_i;
    logic                        ddr_waitrequest_n_i;
    logic                        busy_o;
    logic                        timeout_sticky_o;

    ddr_read_arbiter #(
        .NumRequesters(NumReq),
        .TimeoutCycles(Timeout)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_address_i      (req_address_i),
        .req_ready_o        (req_ready_o),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_data_o         (rsp_data_o),
        .rsp_error_o        (rsp_error_o),
        .ddr_address_o      (ddr_address_o),
        .ddr_r_en_o         (ddr_r_en_o),
        .ddr_r_data_i       (ddr_r_data_i),
        .ddr_r_valid_i      (ddr_r_valid_i),
        .ddr_waitrequest_n_i(ddr_waitrequest_n_i),
        .busy_o             (busy_o),
        .timeout_sticky_o   (timeout_sticky_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int        client;
        ddr_data_t data;
        logic      err;
    } rsp_t;

    rsp_t         expQ[$];
    int           totalChecks = 0;
    int           passedChecks = 0;
    int           modelPtr = 0;
    logic         modelSticky = 1'b0;
    logic [NumReq-1:0] pending = '0;
    ddr_address_t pendAddr[NumReq];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model of the round-robin rule: first pending client from the pointer on.
    function automatic int expectedGrant(input logic [NumReq-1:0] mask, input int ptr);
        for (int k = 0; k < NumReq; k++) begin
            if (mask[(ptr + k) % NumReq]) return (ptr + k) % NumReq;
        end
        return -1;
    endfunction

    task automatic driveRequests();
        req_valid_i = pending;
        for (int i = 0; i < NumReq; i++) begin
            req_address_i[i] = pendAddr[i];
        end
    endtask

    // One arbitration round: new requests, grant check, DDR handshake, response.
    task automatic applyStimulus(input int stalls, input int delay, input bit timeout,
                                 input logic [NumReq-1:0] newMask, input ddr_data_t data);
        int           g;
        int           waitCycles;
        ddr_address_t addr;
        @(posedge clk_i); #1;
        ddr_r_valid_i       = 1'b0;
        ddr_waitrequest_n_i = 1'b1;
        for (int i = 0; i < NumReq; i++) begin
            if (newMask[i] && !pending[i]) begin
                pending[i]  = 1'b1;
                pendAddr[i] = $urandom;
            end
        end
        driveRequests();
        @(negedge clk_i);
        checkOutput("sticky", timeout_sticky_o, modelSticky);
        g = expectedGrant(pending, modelPtr);
        if (g < 0) begin
            checkOutput("idle_ready", req_ready_o, 0);
            checkOutput("idle_busy", busy_o, 0);
            return;
        end
        checkOutput("ready_grant", req_ready_o, 64'(1) << g);
        addr = pendAddr[g];
        for (int s = 0; s <= stalls; s++) begin
            @(posedge clk_i); #1;
            if (s == 0) begin
                pending[g] = 1'b0;
                driveRequests();
            end
            ddr_waitrequest_n_i = (s == stalls);
            @(negedge clk_i);
            checkOutput("issue_r_en", ddr_r_en_o, 1);
            checkOutput("issue_address", ddr_address_o, addr);
            checkOutput("issue_ready", req_ready_o, 0);
        end
        if (timeout) expQ.push_back('{g, '0, 1'b1});
        else         expQ.push_back('{g, data, 1'b0});
        waitCycles = timeout ? Timeout : delay + 1;
        for (int w = 0; w < waitCycles; w++) begin
            @(posedge clk_i); #1;
            if (!timeout && w == delay) begin
                ddr_r_valid_i       = 1'b1;
                ddr_r_data_i        = data;
                ddr_waitrequest_n_i = 1'b1;
            end else begin
                // Valid without waitrequest_n must not complete the read.
                ddr_r_valid_i       = ($urandom_range(0, 3) == 0);
                ddr_waitrequest_n_i = ~ddr_r_valid_i;
                ddr_r_data_i        = {$urandom, $urandom};
            end
            @(negedge clk_i);
            checkOutput("wait_r_en", ddr_r_en_o, 0);
            checkOutput("wait_busy", busy_o, 1);
        end
        modelPtr = (g + 1) % NumReq;
        if (timeout) modelSticky = 1'b1;
    endtask

    // Reset in WAIT_DATA drops the read; a stray valid afterwards is ignored.
    task automatic applyResetMidRead();
        int g;
        @(posedge clk_i); #1;
        ddr_r_valid_i       = 1'b0;
        ddr_waitrequest_n_i = 1'b1;
        if (pending == '0) begin
            pending[0]  = 1'b1;
            pendAddr[0] = $urandom;
        end
        driveRequests();
        @(negedge clk_i);
        g = expectedGrant(pending, modelPtr);
        checkOutput("rst_ready_grant", req_ready_o, 64'(1) << g);
        @(posedge clk_i); #1;
        pending[g] = 1'b0;
        driveRequests();
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checkOutput("rst_pre_busy", busy_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_r_en", ddr_r_en_o, 0);
        checkOutput("rst_address", ddr_address_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("rst_rsp_error", rsp_error_o, 0);
        checkOutput("rst_rsp_data", rsp_data_o, 0);
        checkOutput("rst_sticky", timeout_sticky_o, 0);
        checkOutput("rst_ready", req_ready_o, 0);
        modelPtr    = 0;
        modelSticky = 1'b0;
        pending     = '0;
        driveRequests();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        ddr_r_valid_i = 1'b1;
        ddr_r_data_i  = {$urandom, $urandom};
        @(negedge clk_i);
        checkOutput("stray_busy", busy_o, 0);
        @(posedge clk_i); #1;
        ddr_r_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("stray_rsp", rsp_valid_o, 0);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o != '0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_rsp", rsp_valid_o, 0);
            end else begin
                rsp_t e;
                e = expQ.pop_front();
                checkOutput("rsp_valid", rsp_valid_o, 64'(1) << e.client);
                checkOutput("rsp_data", rsp_data_o, e.data);
                checkOutput("rsp_error", rsp_error_o, e.err);
            end
        end
    end

    initial begin
        req_valid_i         = '0;
        req_address_i       = '0;
        ddr_r_data_i        = '0;
        ddr_r_valid_i       = 1'b0;
        ddr_waitrequest_n_i = 1'b1;
        for (int i = 0; i < NumReq; i++) pendAddr[i] = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_r_en", ddr_r_en_o, 0);
        checkOutput("reset_address", ddr_address_o, 0);
        checkOutput("reset_rsp_valid", rsp_valid_o, 0);
        checkOutput("reset_rsp_data", rsp_data_o, 0);
        checkOutput("reset_sticky", timeout_sticky_o, 0);
        rst_ni = 1'b1;

        pending[0]  = 1'b1;
        pendAddr[0] = 32'h100;
        applyStimulus(0, 2, 1'b0, 4'b0000, 64'hAB);

        pending     = 4'b1111;
        pendAddr[0] = 32'h10;
        pendAddr[1] = 32'h20;
        pendAddr[2] = 32'h30;
        pendAddr[3] = 32'h40;
        for (int r = 0; r < 4; r++) applyStimulus(0, r, 1'b0, 4'b0000, {$urandom, $urandom});
        applyStimulus(1, 0, 1'b0, 4'b0001, {$urandom, $urandom});

        applyStimulus(5, 1, 1'b0, 4'b0010, {$urandom, $urandom});
        applyStimulus(0, 0, 1'b1, 4'b0100, '0);
        applyStimulus(0, Timeout - 1, 1'b0, 4'b1000, {$urandom, $urandom});
        applyStimulus(0, 0, 1'b0, 4'b0010, {$urandom, $urandom});
        applyStimulus(0, 0, 1'b0, 4'b1010, {$urandom, $urandom});

        applyResetMidRead();
        applyStimulus(0, 0, 1'b0, 4'b0101, {$urandom, $urandom});

        for (int t = 0; t < 150; t++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, Timeout - 1),
                          ($urandom_range(0, 9) == 0), 4'($urandom), {$urandom, $urandom});
        end

        @(posedge clk_i); #1;
        ddr_r_valid_i = 1'b0;
        pending       = '0;
        driveRequests();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("final_queue_empty", 64'(expQ.size()), 0);
        checkOutput("final_busy", busy_o, 0);
        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
